// File: rtl/dmem_responder_if.sv
// Data-side memory request/response bus between the MIPS MEM stage and the responder.
interface dmem_responder_if;
  logic        req;
  logic [31:0] addr;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        err;

  modport master (output req, addr, we, wdata, input rdata, stall, err);
  modport slave  (input req, addr, we, wdata, output rdata, stall, err);
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM responder with fixed wait states, pipeline stall,
// byte-lane writes and out-of-range / misalignment error reporting.
module dmem_responder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned WAIT   = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);

  localparam int unsigned DEPTH     = 1 << ADDR_W;
  localparam int unsigned HI_LSB    = ADDR_W + 2;
  localparam bit          NO_WAIT   = (WAIT == 0);
  localparam logic [3:0]  WAIT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [3:0]        waitCnt;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wordIdx;
  logic              outOfRange;
  logic              misaligned;
  logic              execute;
  logic              wrOk;

  assign wordIdx    = bus.addr[ADDR_W+1:2];
  assign outOfRange = (bus.addr >> HI_LSB) != 32'd0;
  // Only stores can be misaligned; reads return the whole word for lane slicing.
  assign misaligned = ((bus.we == 4'b1111) && (bus.addr[1:0] != 2'b00)) ||
                      (((bus.we == 4'b1100) || (bus.we == 4'b0011)) && bus.addr[0]);
  assign execute    = rst && bus.req &&
                      (((state == IDLE) && NO_WAIT) || ((state == BUSY) && (waitCnt == 4'd0)));
  assign wrOk       = execute && !outOfRange && !misaligned;

  assign bus.stall  = bus.req && ((state == IDLE) || (state == BUSY));

  // RAM is never reset; byte lanes written independently.
  always_ff @(posedge clk) begin
    if (wrOk) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.we[i]) mem[wordIdx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  // Access sequencing; rdata captures pre-write contents on the executing edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      waitCnt   <= 4'd0;
      bus.rdata <= 32'h0;
      bus.err   <= 1'b0;
    end else begin
      bus.err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req && !NO_WAIT) begin
            waitCnt <= WAIT_INIT;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (!bus.req) begin
            state <= IDLE;
          end else if (waitCnt != 4'd0) begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (execute) begin
        state     <= DONE;
        bus.rdata <= outOfRange ? 32'h0 : mem[wordIdx];
        bus.err   <= outOfRange || misaligned;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: WAIT=2 instance for most cases, WAIT=0 for back-to-back.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  int   nCmp = 0;
  int   nBad = 0;

  always #5 clk = ~clk;

  dmem_responder_if b2();
  dmem_responder_if b0();

  dmem_responder #(.ADDR_W(10), .WAIT(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  dmem_responder #(.ADDR_W(10), .WAIT(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one held request on the WAIT=2 bus; entered and left at posedge+1.
  task automatic acc(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                     output int ns, output logic [31:0] rd, output logic e);
    b2.req = 1'b1; b2.addr = a; b2.we = w; b2.wdata = d;
    ns = 0; rd = '0; e = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!b2.stall) break;
      ns++;
      @(posedge clk); #1;
    end
    rd = b2.rdata;
    e  = b2.err;
    @(posedge clk); #1;
    b2.req = 1'b0;
    @(negedge clk);
    chk("errPulseEnd", 32'(b2.err), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int          ns;
    logic [31:0] rd;
    logic        e;

    rst = 1'b0;
    b2.req = 1'b0; b2.addr = '0; b2.we = '0; b2.wdata = '0;
    b0.req = 1'b0; b0.addr = '0; b0.we = '0; b0.wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rstStall", 32'(b2.stall), 32'd0);
    chk("rstRdata", b2.rdata, 32'h0);
    chk("rstErr", 32'(b2.err), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // word store then load
    acc(32'h10, 4'b1111, 32'hDEADBEEF, ns, rd, e);
    chk("stStall", 32'(ns), 32'd3);
    chk("stErr", 32'(e), 32'd0);
    acc(32'h10, 4'b0000, 32'h0, ns, rd, e);
    chk("ldStall", 32'(ns), 32'd3);
    chk("ldData", rd, 32'hDEADBEEF);
    chk("ldErr", 32'(e), 32'd0);

    // byte store to lane 1
    acc(32'h12, 4'b0010, 32'h5A5A5A5A, ns, rd, e);
    chk("sbPreData", rd, 32'hDEADBEEF);
    chk("sbErr", 32'(e), 32'd0);
    acc(32'h10, 4'b0000, 32'h0, ns, rd, e);
    chk("sbReadBack", rd, 32'hDEAD5AEF);

    // flush abort from BUSY
    b2.req = 1'b1; b2.addr = 32'h10; b2.we = 4'b1111; b2.wdata = 32'h11111111;
    @(posedge clk);
    @(posedge clk); #1;
    b2.req = 1'b0;
    @(negedge clk);
    chk("flushStall", 32'(b2.stall), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("flushErr", 32'(b2.err), 32'd0);
    chk("flushRdata", b2.rdata, 32'hDEAD5AEF);
    @(posedge clk); #1;
    acc(32'h10, 4'b0000, 32'h0, ns, rd, e);
    chk("flushIdleStall", 32'(ns), 32'd3);
    chk("flushRam", rd, 32'hDEAD5AEF);

    // out-of-range store must not alias word 0
    acc(32'h0, 4'b1111, 32'hCAFEF00D, ns, rd, e);
    acc(32'h1000, 4'b1111, 32'h12345678, ns, rd, e);
    chk("oorErr", 32'(e), 32'd1);
    chk("oorRdata", rd, 32'h0);
    chk("oorStall", 32'(ns), 32'd3);
    acc(32'h0, 4'b0000, 32'h0, ns, rd, e);
    chk("oorNoAlias", rd, 32'hCAFEF00D);

    // misaligned stores
    acc(32'h20, 4'b1111, 32'h0BADC0DE, ns, rd, e);
    acc(32'h22, 4'b1111, 32'hFFFFFFFF, ns, rd, e);
    chk("misWErr", 32'(e), 32'd1);
    chk("misWRdata", rd, 32'h0BADC0DE);
    acc(32'h21, 4'b0011, 32'hFFFFFFFF, ns, rd, e);
    chk("misHErr", 32'(e), 32'd1);
    acc(32'h23, 4'b0000, 32'h0, ns, rd, e);
    chk("oddReadErr", 32'(e), 32'd0);
    chk("misUnchanged", rd, 32'h0BADC0DE);

    // asynchronous reset while BUSY
    b2.req = 1'b1; b2.addr = 32'h10; b2.we = 4'b1111; b2.wdata = 32'h99999999;
    @(posedge clk); #2;
    chk("busyStall", 32'(b2.stall), 32'd1);
    b2.req = 1'b0;
    rst = 1'b0;
    #1;
    chk("asyncRdata", b2.rdata, 32'h0);
    chk("asyncStall", 32'(b2.stall), 32'd0);
    chk("asyncErr", 32'(b2.err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    acc(32'h10, 4'b0000, 32'h0, ns, rd, e);
    chk("postRstStall", 32'(ns), 32'd3);
    chk("postRstRam", rd, 32'hDEAD5AEF);

    // WAIT=0 back-to-back: store then read in consecutive cycles
    b0.req = 1'b1; b0.addr = 32'h40; b0.we = 4'b1111; b0.wdata = 32'h13579BDF;
    @(negedge clk);
    chk("b2bStall0", 32'(b0.stall), 32'd1);
    @(posedge clk); #1;
    b0.we = 4'b0000;
    @(negedge clk);
    chk("b2bStall1", 32'(b0.stall), 32'd0);
    chk("b2bErr1", 32'(b0.err), 32'd0);
    @(negedge clk);
    chk("b2bStall2", 32'(b0.stall), 32'd1);
    @(negedge clk);
    chk("b2bStall3", 32'(b0.stall), 32'd0);
    chk("b2bRdata", b0.rdata, 32'h13579BDF);
    @(posedge clk); #1;
    b0.req = 1'b0;
    @(negedge clk);
    chk("b2bIdle", 32'(b0.stall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
